// File: rtl/register_arbiter_pkg.sv
// Shared types for the register-port arbiter: FSM state encoding, requester
// count and a grant-index to one-hot helper.
package register_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int N_REQ = 2;

  function automatic logic [N_REQ-1:0] req_onehot(input logic idx);
    logic [N_REQ-1:0] vec;
    if (idx) begin
      vec = 2'b10;
    end else begin
      vec = 2'b01;
    end
    return vec;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin picker: on contention the requester that did not win
// last time is chosen; a lone requester always wins.
module rr_arbiter_2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  // combinational pick
  always_comb begin
    gnt_valid = |req;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last_grant;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/register_port_arbiter.sv
// Shares one register_block port between two requesters, serialising their
// accesses into single-cycle strobes and routing read data/acks back.
module register_port_arbiter
  import register_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             i_reset,
  input  logic [N_REQ-1:0]                 i_req,
  input  logic [N_REQ-1:0]                 i_we,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0] i_addr,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_wdata,
  output logic [N_REQ-1:0]                 o_ack,
  output logic [N_REQ-1:0]                 o_err,
  output logic [DATA_WIDTH-1:0]            o_rdata,
  output logic                             o_w_en,
  output logic [ADDR_WIDTH-1:0]            o_w_addr,
  output logic [DATA_WIDTH-1:0]            o_w_value,
  output logic                             o_r_en,
  output logic [ADDR_WIDTH-1:0]            o_r_addr,
  input  logic [DATA_WIDTH-1:0]            i_r_value,
  input  logic                             i_r_valid
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_t state, state_nxt;

  logic                  gnt, gnt_nxt;
  logic                  we, we_nxt;
  logic [ADDR_WIDTH-1:0] addr, addr_nxt;
  logic [DATA_WIDTH-1:0] wdata, wdata_nxt;
  logic                  last_grant, last_grant_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, cnt_inc;
  logic [N_REQ-1:0]      mask;
  logic [N_REQ-1:0]      ack_nxt, err_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic                  w_en_nxt, r_en_nxt;
  logic [N_REQ-1:0]      eligible;
  logic                  gnt_valid, gnt_idx;

  // A requester acked last cycle may still show a stale request; skip it once.
  assign eligible = i_req & ~mask;

  rr_arbiter_2 u_rr (
    .req        (eligible),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  // state register
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state and next-output decode; outputs are computed one cycle ahead
  // so every port comes straight from a flop
  always_comb begin
    state_nxt      = state;
    gnt_nxt        = gnt;
    we_nxt         = we;
    addr_nxt       = addr;
    wdata_nxt      = wdata;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    rdata_nxt      = o_rdata;
    ack_nxt        = {N_REQ{1'b0}};
    err_nxt        = {N_REQ{1'b0}};
    w_en_nxt       = 1'b0;
    r_en_nxt       = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          gnt_nxt        = gnt_idx;
          we_nxt         = i_we[gnt_idx];
          addr_nxt       = i_addr[gnt_idx];
          wdata_nxt      = i_wdata[gnt_idx];
          last_grant_nxt = gnt_idx;
          state_nxt      = ISSUE;
          if (i_we[gnt_idx]) begin
            w_en_nxt = 1'b1;
            ack_nxt  = req_onehot(gnt_idx);
          end else begin
            r_en_nxt = 1'b1;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE: begin
        if (we) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = {CW{1'b0}};
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (i_r_valid) begin
          rdata_nxt = i_r_value;
          ack_nxt   = req_onehot(gnt);
          state_nxt = RESP;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = cnt_inc;
          rdata_nxt = {DATA_WIDTH{1'b0}};
          ack_nxt   = req_onehot(gnt);
          err_nxt   = req_onehot(gnt);
          state_nxt = RESP;
        end else begin
          cnt_nxt   = cnt_inc;
          state_nxt = WAIT;
        end
      end
      RESP: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // transaction fields, counter, mask and registered outputs
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      gnt        <= 1'b0;
      we         <= 1'b0;
      addr       <= {ADDR_WIDTH{1'b0}};
      wdata      <= {DATA_WIDTH{1'b0}};
      last_grant <= 1'b1;
      cnt        <= {CW{1'b0}};
      mask       <= {N_REQ{1'b0}};
      o_ack      <= {N_REQ{1'b0}};
      o_err      <= {N_REQ{1'b0}};
      o_rdata    <= {DATA_WIDTH{1'b0}};
      o_w_en     <= 1'b0;
      o_r_en     <= 1'b0;
    end else begin
      gnt        <= gnt_nxt;
      we         <= we_nxt;
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
      mask       <= o_ack;
      o_ack      <= ack_nxt;
      o_err      <= err_nxt;
      o_rdata    <= rdata_nxt;
      o_w_en     <= w_en_nxt;
      o_r_en     <= r_en_nxt;
    end
  end

  assign o_w_addr  = addr;
  assign o_w_value = wdata;
  assign o_r_addr  = addr;

endmodule
